// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus valid/ready output stream of the burst reader.
// The master side is the reader; the slave side is the FIFO and consumer.
interface fifo_burst_reader_if #(
  parameter int WIDTH = 32
);
  logic             fifo_read_en;
  logic             fifo_empty_n;
  logic [WIDTH-1:0] fifo_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    output fifo_read_en,
    input  fifo_empty_n,
    input  fifo_data,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    input  fifo_read_en,
    output fifo_empty_n,
    output fifo_data,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a fixed-length burst from a registered-output FIFO into a valid/ready
// stream with a last marker, using a two-entry skid buffer to hide read latency.
module fifo_burst_reader #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     burst_len,
  output logic                 busy,
  output logic                 done,
  fifo_burst_reader_if.master  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] issued_r;
  logic [CNT_W-1:0] delivered_r;
  logic             inflight_r;
  logic [1:0]       buf_cnt_r;
  logic [WIDTH-1:0] buf0_r;
  logic [WIDTH-1:0] buf1_r;

  logic             pop_s;
  logic             push_s;
  logic             rd_s;
  logic             last_s;
  logic [1:0]       occ_s;

  // Read issue: occupancy counts buffered words plus the one in flight, net of this cycle's pop.
  always_comb begin
    pop_s  = (buf_cnt_r != 2'd0) && bus.m_ready;
    push_s = inflight_r && (state_r == ST_RUN);
    occ_s  = buf_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    last_s = (delivered_r == (len_r - CNT_W'(1)));
    if (!rst && (state_r == ST_RUN) && bus.fifo_empty_n &&
        (issued_r < len_r) && (occ_s < 2'd2)) begin
      rd_s = 1'b1;
    end else begin
      rd_s = 1'b0;
    end
  end

  assign bus.fifo_read_en = rd_s;
  assign bus.m_valid      = (buf_cnt_r != 2'd0);
  assign bus.m_data       = buf0_r;
  assign bus.m_last       = (buf_cnt_r != 2'd0) && last_s;
  assign busy             = (state_r != ST_IDLE);
  assign done             = (state_r == ST_DONE);

  // Burst sequencing and issue/delivery counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      len_r       <= {CNT_W{1'b0}};
      issued_r    <= {CNT_W{1'b0}};
      delivered_r <= {CNT_W{1'b0}};
      inflight_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r       <= burst_len;
            issued_r    <= {CNT_W{1'b0}};
            delivered_r <= {CNT_W{1'b0}};
            inflight_r  <= 1'b0;
            state_r     <= (burst_len == {CNT_W{1'b0}}) ? ST_DONE : ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          issued_r   <= issued_r + CNT_W'(rd_s);
          inflight_r <= rd_s;
          if (pop_s) begin
            delivered_r <= delivered_r + CNT_W'(1);
            if (last_s) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Skid buffer: head feeds m_data; returning read data lands at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt_r <= 2'd0;
      buf0_r    <= {WIDTH{1'b0}};
      buf1_r    <= {WIDTH{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (buf_cnt_r == 2'd0) begin
            buf0_r <= bus.fifo_data;
          end else begin
            buf1_r <= bus.fifo_data;
          end
          buf_cnt_r <= buf_cnt_r + 2'd1;
        end
        2'b01: begin
          buf0_r    <= buf1_r;
          buf_cnt_r <= buf_cnt_r - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_r == 2'd1) begin
            buf0_r <= bus.fifo_data;
          end else begin
            buf0_r <= buf1_r;
            buf1_r <= bus.fifo_data;
          end
        end
        default: begin
          buf_cnt_r <= buf_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a FIFO model feeds the DUT, a scoreboard
// queue holds expected words and a negedge monitor checks every handshake.
module tb_fifo_burst_reader;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic             busy;
  logic             done;

  fifo_burst_reader_if #(.WIDTH(WIDTH)) bus ();

  fifo_burst_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH:0]   mon_e;
  bit               rd_pend;
  int               n_checks = 0;
  int               n_fail = 0;
  int               rd_count = 0;
  int               pop_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // FIFO model: registered read data one cycle after fifo_read_en.
  initial begin
    bus.fifo_empty_n = 1'b0;
    bus.fifo_data    = '0;
    forever begin
      @(negedge clk);
      rd_pend = bus.fifo_read_en;
      @(posedge clk);
      #1;
      if (rd_pend && fifo_q.size() != 0) bus.fifo_data = fifo_q.pop_front();
      #1;
      bus.fifo_empty_n = (fifo_q.size() != 0);
    end
  end

  // Monitor: compare each accepted word against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.fifo_read_en) rd_count++;
      check("rd_while_empty", {63'd0, bus.fifo_read_en & ~bus.fifo_empty_n}, 64'd0);
      if (bus.m_valid && bus.m_ready) begin
        pop_count++;
        check("exp_q_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("m_data", 64'(bus.m_data), 64'(mon_e[WIDTH-1:0]));
          check("m_last", {63'd0, bus.m_last}, {63'd0, mon_e[WIDTH]});
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic fifo_push(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + WIDTH'(i));
  endtask

  task automatic exp_push(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + WIDTH'(i)});
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else next();
    end
    check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    next();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"},  {63'd0, busy}, 64'd0);
    check({name, "_done"},  {63'd0, done}, 64'd0);
    check({name, "_valid"}, {63'd0, bus.m_valid}, 64'd0);
    check({name, "_last"},  {63'd0, bus.m_last}, 64'd0);
    check({name, "_rd"},    {63'd0, bus.fifo_read_en}, 64'd0);
    check({name, "_data"},  64'(bus.m_data), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, p0, rb;
    rst = 1'b1; start = 1'b0; burst_len = '0; bus.m_ready = 1'b0;

    // Reset with random inputs
    for (int c = 0; c < 2; c++) begin
      next();
      start = 1'($urandom); burst_len = CNT_W'($urandom); bus.m_ready = 1'($urandom);
      smp();
      check_idle_outputs("rst");
    end
    next();
    rst = 1'b0; start = 1'b0; bus.m_ready = 1'b1;
    smp();
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    // Burst of 4, full throughput, cycle-exact
    next();
    fifo_push(32'hA0, 4); exp_push(32'hA0, 4);
    next();
    start = 1'b1; burst_len = 8'd4; r0 = rd_count;
    smp();
    check("b4_busy_c0", {63'd0, busy}, 64'd0);
    for (int c = 1; c <= 8; c++) begin
      next();
      start = 1'b0;
      smp();
      check($sformatf("b4_rd_c%0d", c),    {63'd0, bus.fifo_read_en}, 64'(c >= 1 && c <= 4));
      check($sformatf("b4_valid_c%0d", c), {63'd0, bus.m_valid},      64'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check($sformatf("b4_data_c%0d", c), 64'(bus.m_data), 64'(32'hA0 + c - 3));
      check($sformatf("b4_last_c%0d", c),  {63'd0, bus.m_last},       64'(c == 6));
      check($sformatf("b4_done_c%0d", c),  {63'd0, done},             64'(c == 7));
      check($sformatf("b4_busy_c%0d", c),  {63'd0, busy},             64'(c <= 7));
    end
    next();
    check("b4_reads", 64'(rd_count - r0), 64'd4);
    check("b4_exp_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure, burst of 8: stall 5 cycles after the 2nd word
    fifo_push(32'hB0, 8); exp_push(32'hB0, 8);
    next();
    start = 1'b1; burst_len = 8'd8; r0 = rd_count; p0 = pop_count;
    for (int c = 1; c <= 4; c++) begin
      next();
      start = 1'b0;
    end
    next();
    bus.m_ready = 1'b0; rb = rd_count;
    check("bp_two_popped", 64'(pop_count - p0), 64'd2);
    for (int c = 5; c <= 9; c++) begin
      if (c > 5) next();
      smp();
    end
    check("bp_rd_held_low", {63'd0, bus.fifo_read_en}, 64'd0);
    check("bp_valid_held", {63'd0, bus.m_valid}, 64'd1);
    next();
    bus.m_ready = 1'b1;
    check("bp_extra_reads_le2", {63'd0, (rd_count - rb) <= 2}, 64'd1);
    smp();
    check("bp_reissue_on_pop", {63'd0, bus.fifo_read_en}, 64'd1);
    wait_done("bp", 40);
    check("bp_reads", 64'(rd_count - r0), 64'd8);
    check("bp_pops", 64'(pop_count - p0), 64'd8);
    check("bp_exp_empty", 64'(exp_q.size()), 64'd0);

    // Underrun: burst of 3 with 1 word available
    fifo_push(32'hC0, 1); exp_push(32'hC0, 3);
    next();
    start = 1'b1; burst_len = 8'd3; r0 = rd_count;
    for (int c = 1; c <= 6; c++) begin
      next();
      start = 1'b0;
      smp();
      check($sformatf("ur_busy_c%0d", c), {63'd0, busy}, 64'd1);
    end
    check("ur_valid_drained", {63'd0, bus.m_valid}, 64'd0);
    next();
    check("ur_one_read", 64'(rd_count - r0), 64'd1);
    fifo_push(32'hC1, 2);
    smp();
    check("ur_resume_rd", {63'd0, bus.fifo_read_en}, 64'd1);
    wait_done("ur", 20);
    check("ur_reads", 64'(rd_count - r0), 64'd3);
    check("ur_exp_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length burst
    next();
    start = 1'b1; burst_len = 8'd0; r0 = rd_count; p0 = pop_count;
    next();
    start = 1'b0;
    smp();
    check("z_done_c1", {63'd0, done}, 64'd1);
    check("z_busy_c1", {63'd0, busy}, 64'd1);
    check("z_valid_c1", {63'd0, bus.m_valid}, 64'd0);
    next();
    smp();
    check("z_busy_c2", {63'd0, busy}, 64'd0);
    check("z_valid_c2", {63'd0, bus.m_valid}, 64'd0);
    next();
    check("z_reads", 64'(rd_count - r0), 64'd0);
    check("z_pops", 64'(pop_count - p0), 64'd0);

    // Start held during every busy cycle of a 4-word burst is ignored
    fifo_push(32'hD0, 4); exp_push(32'hD0, 4);
    next();
    start = 1'b1; burst_len = 8'd4; p0 = pop_count;
    for (int c = 1; c <= 9; c++) begin
      next();
      start = (c <= 7); burst_len = 8'd9;
      smp();
      check($sformatf("ig_done_c%0d", c), {63'd0, done}, 64'(c == 7));
      check($sformatf("ig_busy_c%0d", c), {63'd0, busy}, 64'(c <= 7));
    end
    next();
    start = 1'b0;
    check("ig_pops", 64'(pop_count - p0), 64'd4);
    check("ig_exp_empty", 64'(exp_q.size()), 64'd0);

    // Reset in cycle 4 of an 8-word burst, then a clean 2-word burst
    fifo_push(32'hE0, 8); exp_push(32'hE0, 8);
    next();
    start = 1'b1; burst_len = 8'd8;
    for (int c = 1; c <= 3; c++) begin
      next();
      start = 1'b0;
    end
    next();
    rst = 1'b1; exp_q.delete();
    smp();
    check("mr_rd_in_rst", {63'd0, bus.fifo_read_en}, 64'd0);
    next();
    rst = 1'b0; fifo_q.delete();
    smp();
    check_idle_outputs("mr_after");
    next();
    fifo_push(32'hF0, 2); exp_push(32'hF0, 2);
    next();
    start = 1'b1; burst_len = 8'd2; r0 = rd_count; p0 = pop_count;
    next();
    start = 1'b0;
    wait_done("mr_new", 20);
    smp();
    check("mr_new_busy_low", {63'd0, busy}, 64'd0);
    next();
    check("mr_new_reads", 64'(rd_count - r0), 64'd2);
    check("mr_new_pops", 64'(pop_count - p0), 64'd2);
    check("mr_new_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
